// File: rtl/result_requant.sv
// Result-memory drain with requantization: reads NUM_NEURONS signed
// accumulators in address order, scales/rounds/shifts/clamps each one to
// OUT_WIDTH bits, and streams them out through a 4-entry ready/valid FIFO.
module result_requant #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_NEURONS = 32,
  parameter int SCALE_WIDTH = 16,
  parameter int OUT_WIDTH   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [SCALE_WIDTH-1:0]  mult,
  input  logic [4:0]              shift,
  input  logic                    relu_en,
  output logic                    res_rd_en,
  output logic [ADDR_WIDTH-1:0]   res_rd_addr,
  input  logic [2*DATA_WIDTH-1:0] res_rd_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_WIDTH-1:0]    out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done
);

  localparam int ACC_W = 2 * DATA_WIDTH;
  localparam int PW    = ACC_W + SCALE_WIDTH + 1;
  localparam int CNT_W = $clog2(NUM_NEURONS + 1);

  localparam logic signed [PW-1:0] SAT_MAX = {{(PW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = {{(PW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t state, state_next;

  logic [SCALE_WIDTH-1:0] mult_q;
  logic [4:0]             shift_q;
  logic                   relu_q;
  logic [CNT_W-1:0]       cnt;
  logic                   inflight;
  logic                   inflight_last;
  logic                   rd_issue;
  logic                   push;
  logic                   pop;

  logic [OUT_WIDTH-1:0]   fifo_data [4];
  logic                   fifo_last [4];
  logic [1:0]             wr_ptr;
  logic [1:0]             rd_ptr;
  logic [2:0]             occ;

  logic signed [PW-1:0]   acc_ext;
  logic signed [PW-1:0]   mult_ext;
  logic signed [PW-1:0]   prod;
  logic signed [PW-1:0]   rnd;
  logic signed [PW-1:0]   shifted;
  logic [OUT_WIDTH-1:0]   q_result;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state: one run per start, ends after the last element is accepted
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (out_valid && out_ready && out_last) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = (state == RUN);
    done = (state == FINISH);
  end

  // Run configuration latch and read-address counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      mult_q  <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
      cnt     <= '0;
    end else if (state == IDLE && start) begin
      mult_q  <= mult;
      shift_q <= shift;
      relu_q  <= relu_en;
      cnt     <= '0;
    end else if (rd_issue) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Read issue: credit counts FIFO entries plus the read still in flight,
  // so a returned word always has a free slot to land in
  always_comb begin
    rd_issue    = (state == RUN) && (cnt < CNT_W'(NUM_NEURONS)) &&
                  (({1'b0, occ} + {3'b000, inflight}) < 4'd4);
    res_rd_en   = rd_issue;
    res_rd_addr = rd_issue ? ADDR_WIDTH'(cnt) : '0;
  end

  // Track the single outstanding read and whether it is the final element
  always_ff @(posedge clk) begin
    if (!rst) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= rd_issue;
      inflight_last <= rd_issue && (cnt == CNT_W'(NUM_NEURONS - 1));
    end
  end

  // Requantize the returning accumulator: scale, round-half-up, shift, clamp
  always_comb begin
    acc_ext  = {{(PW-ACC_W){res_rd_data[ACC_W-1]}}, res_rd_data};
    mult_ext = {{(PW-SCALE_WIDTH){1'b0}}, mult_q};
    prod     = acc_ext * mult_ext;
    rnd      = '0;
    if (shift_q != 5'd0) rnd[shift_q - 5'd1] = 1'b1;
    shifted  = (prod + rnd) >>> shift_q;
    if (relu_q && shifted[PW-1]) shifted = '0;
    if (shifted > SAT_MAX)      q_result = SAT_MAX[OUT_WIDTH-1:0];
    else if (shifted < SAT_MIN) q_result = SAT_MIN[OUT_WIDTH-1:0];
    else                        q_result = shifted[OUT_WIDTH-1:0];
  end

  // FIFO handshake decode
  always_comb begin
    push = inflight;
    pop  = out_valid && out_ready;
  end

  // Output FIFO storage and pointers
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= q_result;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // FIFO head drives the output stream
  always_comb begin
    out_valid = (occ != 3'd0);
    out_data  = out_valid ? fifo_data[rd_ptr] : '0;
    out_last  = out_valid ? fifo_last[rd_ptr] : 1'b0;
  end

endmodule

// File: tb/tb_result_requant.sv
// Directed bench for result_requant with a behavioural result memory.
module tb_result_requant;

  localparam int NN = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] mult = '0;
  logic [4:0]  shift = '0;
  logic        relu_en = 1'b0;
  logic        res_rd_en;
  logic [9:0]  res_rd_addr;
  logic [31:0] res_rd_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic signed [31:0] mem [NN];
  int exp_data [NN];

  int rx_data [$];
  bit rx_last [$];
  int done_cnt, done_cyc, first_rd, first_vld, last_hs;
  int pending = 0;
  bit prev_stall = 0;
  logic [7:0] prev_data;
  logic prev_last;
  bit rand_mode = 0;

  result_requant #(
    .ADDR_WIDTH(10), .DATA_WIDTH(16), .NUM_NEURONS(NN),
    .SCALE_WIDTH(16), .OUT_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mult(mult), .shift(shift),
    .relu_en(relu_en), .res_rd_en(res_rd_en), .res_rd_addr(res_rd_addr),
    .res_rd_data(res_rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (res_rd_en) res_rd_data <= mem[res_rd_addr[4:0]];

  task automatic check(input string tag, input longint obs, input longint expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Stream monitor: credit limit, stall stability, handshake capture, done
  always @(negedge clk) begin
    if (!rst) begin
      pending    = 0;
      prev_stall = 0;
    end else begin
      if (res_rd_en) begin
        check("rd_credit", pending < 4, 1);
        if (first_rd < 0) first_rd = cyc;
      end
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, prev_data);
        check("stall_last", out_last, prev_last);
      end
      if (out_valid && first_vld < 0) first_vld = cyc;
      if (out_valid && out_ready) begin
        rx_data.push_back(int'($signed(out_data)));
        rx_last.push_back(out_last);
        last_hs = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_busy", busy, 0);
      end
      pending    = pending + (res_rd_en ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = rand_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    rx_data.delete();
    rx_last.delete();
    done_cnt  = 0;
    done_cyc  = -1;
    first_rd  = -1;
    first_vld = -1;
    last_hs   = -1;
  endtask

  task automatic check_zero();
    check("rst_rd_en", res_rd_en, 0);
    check("rst_rd_addr", res_rd_addr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
  endtask

  task automatic do_run(input int m, input int s, input bit r,
                        input bit disturb, input bit check_lat);
    int ts;
    clear_mon();
    mult    = 16'(m);
    shift   = 5'(s);
    relu_en = r;
    start   = 1'b1;
    tick();
    ts    = cyc;
    start = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (done_cnt > 0) break;
      if (disturb && n == 5) begin
        start = 1'b1; mult = 16'd7; shift = 5'd3; relu_en = 1'b1;
      end
      if (disturb && n == 6) start = 1'b0;
      tick();
    end
    check("run_done", done_cnt > 0, 1);
    tick(); tick(); tick();
    check("done_count", done_cnt, 1);
    check("rx_count", rx_data.size(), NN);
    for (int i = 0; i < NN && i < rx_data.size(); i++) begin
      check("elem_data", rx_data[i], exp_data[i]);
      check("elem_last", rx_last[i], (i == NN - 1) ? 1 : 0);
    end
    if (check_lat) begin
      check("lat_first_rd", first_rd, ts);
      check("lat_first_valid", first_vld, ts + 2);
      check("lat_done", done_cyc, last_hs + 1);
    end
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < NN; i++) begin
      mem[i]      = 32'(i * 3 - 40);
      exp_data[i] = i * 3 - 40;
    end
  endtask

  task automatic fill_const(input int acc, input int e);
    for (int i = 0; i < NN; i++) begin
      mem[i]      = 32'(acc);
      exp_data[i] = e;
    end
  endtask

  initial begin
    clear_mon();
    rst = 1'b0;
    tick(); tick();
    check_zero();
    rst = 1'b1;
    tick();

    // i*100 / 16 rounded, clamped at 127 from i=21 on
    for (int i = 0; i < NN; i++) begin
      mem[i]      = 32'(i * 100);
      exp_data[i] = (i * 100 + 8) / 16;
      if (exp_data[i] > 127) exp_data[i] = 127;
    end
    do_run(1, 4, 0, 0, 1);

    fill_const(-1000, -128);
    do_run(3, 2, 0, 0, 0);
    fill_const(-1000, 0);
    do_run(3, 2, 1, 0, 0);
    fill_const(-10, -5);
    do_run(1, 1, 0, 0, 0);

    // backpressure with ~30% ready
    fill_ramp();
    rand_mode = 1;
    do_run(1, 0, 0, 0, 0);
    rand_mode = 0;
    tick();

    // restart attempt and config change mid-run are ignored
    fill_ramp();
    do_run(1, 0, 0, 1, 0);

    // reset in the middle of a run
    fill_ramp();
    clear_mon();
    mult = 16'd1; shift = 5'd0; relu_en = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (rx_data.size() >= 10) break;
      tick();
    end
    check("reach_elem10", rx_data.size() >= 10, 1);
    rst = 1'b0;
    tick();
    check_zero();
    rst = 1'b1;
    for (int n = 0; n < 6; n++) tick();
    check("abort_no_done", done_cnt, 0);
    check("abort_idle_busy", busy, 0);
    do_run(1, 0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
